// File: rtl/divider_recon_seq.sv
`default_nettype none
// ============================================================================
// Module   : divider_recon_seq
// Purpose  : Iterative shift-add reconstruction of a division result.
//            Rebuilds dividend = quotient * divisor + remainder, consuming
//            one quotient bit per cycle MSB-first, followed by one add cycle.
//            Valid/ready handshake on both the operand and the result side.
// Config   : RECON_CHECK_EN - when defined, ovf (full result >= 2^N) and
//            rem_err (remainder >= divisor) are computed and registered;
//            when undefined both outputs are tied to 0.
// Ports    : clk        rising-edge clock
//            rst        synchronous active-high reset
//            in_valid   operand triple valid
//            in_ready   unit idle, can accept (high only in IDLE)
//            quotient   [N-M:0]  multiplier operand (K = N-M+1 bits)
//            divisor    [M-1:0]  multiplicand
//            remainder  [M-1:0]  addend
//            out_valid  result valid
//            out_ready  consumer accepts result
//            dividend   [N-1:0]  low N bits of the reconstructed value
//            ovf        full result >= 2^N
//            rem_err    remainder >= divisor
// Revision : 1.0 - initial release
// ============================================================================
module divider_recon_seq #(
    parameter int N = 16,
    parameter int M = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-M:0] quotient,
    input  logic [M-1:0] divisor,
    input  logic [M-1:0] remainder,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] dividend,
    output logic         ovf,
    output logic         rem_err
);

    localparam int K  = N - M + 1;
    localparam int CW = $clog2(K) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_ADD  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]    state_q;
    logic [1:0]    state_d;

    logic [K-1:0]  qs_q;
    logic [M-1:0]  ds_q;
    logic [M-1:0]  rs_q;
    logic [N:0]    acc_q;
    logic [CW-1:0] cnt_q;
    logic          out_valid_q;
    logic [N-1:0]  dividend_q;

    logic [N:0]    ds_ext;
    logic [N:0]    rs_ext;
    logic [N:0]    acc_mul;
    logic [N:0]    acc_sum;
    logic          last_bit;

    assign ds_ext = {{(N+1-M){1'b0}}, ds_q};
    assign rs_ext = {{(N+1-M){1'b0}}, rs_q};

    // The largest possible product-plus-remainder fits in N+1 bits, so the
    // accumulator never wraps, neither in the shift-add nor in the final add.
    assign acc_mul  = (acc_q << 1) + (qs_q[K-1] ? ds_ext : '0);
    assign acc_sum  = acc_q + rs_ext;
    assign last_bit = (cnt_q == CW'(K - 1));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (in_valid)  state_d = S_MUL;
            S_MUL:  if (last_bit)  state_d = S_ADD;
            S_ADD:                 state_d = S_DONE;
            S_DONE: if (out_ready) state_d = S_IDLE;
            default:               state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic
    // ------------------------------------------------------------------
    always_comb begin
        in_ready = (state_q == S_IDLE);
    end

    // ------------------------------------------------------------------
    // Datapath and registered result
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            qs_q        <= '0;
            ds_q        <= '0;
            rs_q        <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            dividend_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        qs_q  <= quotient;
                        ds_q  <= divisor;
                        rs_q  <= remainder;
                        acc_q <= '0;
                        cnt_q <= '0;
                    end
                end
                S_MUL: begin
                    acc_q <= acc_mul;
                    qs_q  <= qs_q << 1;
                    cnt_q <= cnt_q + 1'b1;
                end
                S_ADD: begin
                    acc_q       <= acc_sum;
                    dividend_q  <= acc_sum[N-1:0];
                    out_valid_q <= 1'b1;
                end
                S_DONE: begin
                    // Result is held stable until the consumer takes it.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign dividend  = dividend_q;

    // ------------------------------------------------------------------
    // Optional result checks
    // ------------------------------------------------------------------
`ifdef RECON_CHECK_EN
    logic ovf_q;
    logic rem_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q     <= 1'b0;
            rem_err_q <= 1'b0;
        end else if (state_q == S_ADD) begin
            ovf_q     <= acc_sum[N];
            // A zero divisor always flags, since any remainder is >= 0.
            rem_err_q <= (rs_q >= ds_q);
        end
    end

    assign ovf     = ovf_q;
    assign rem_err = rem_err_q;
`else
    assign ovf     = 1'b0;
    assign rem_err = 1'b0;
`endif

endmodule
`default_nettype wire
